// File: rtl/riscv_pkg.sv
// Shared types and MMIO constants for the PYNQ-Z2 RISC-V top level.
// Holds the UART receiver state encoding and the receive status layout.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam logic [31:0] UART_RX_DATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] UART_RX_STAT_ADDR = 32'h1000_0004;
  localparam int unsigned UART_STAT_VALID_BIT   = 0;
  localparam int unsigned UART_STAT_OVERRUN_BIT = 1;

  // Status word as read through the MMIO decode.
  typedef struct packed {
    logic [29:0] rsvd;
    logic        overrun;
    logic        valid;
  } uart_rx_status_t;

  // Rounded clocks-per-bit divider.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic uart_rx_status_t uart_rx_status(input logic valid,
                                                     input logic overrun);
    uart_rx_status_t s;
    s         = '0;
    s.valid   = valid;
    s.overrun = overrun;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Parameterized synchronous FIFO with a registered head and valid flag.
// Pointers carry one extra wrap bit; full/empty come from the MSB compare.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full_c,
  output logic             empty_c,
  output logic [WIDTH-1:0] head,
  output logic             valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_n, rd_ptr_n;
  logic             push_ok, pop_ok;
  logic             valid_n;
  logic [WIDTH-1:0] head_n;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty_c;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok = push && (!full_c || pop_ok);

  // Next pointers and next head, so head/valid can be registered.
  always_comb begin
    wr_ptr_n = wr_ptr + PW'(push_ok);
    rd_ptr_n = rd_ptr + PW'(pop_ok);
    valid_n  = (wr_ptr_n != rd_ptr_n);
    head_n   = '0;
    if (valid_n) begin
      if (push_ok && (wr_ptr == rd_ptr_n)) head_n = din;
      else                                 head_n = mem[rd_ptr_n[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
      valid  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      head   <= head_n;
      valid  <= valid_n;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and receive FIFO.
// Exposes FIFO head/valid plus frame-error pulse and sticky overrun.
module uart_rx
  import riscv_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_pop,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT);

  uart_rx_state_t state;
  logic           rx_meta, rxs, rxs_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     idx;
  logic [7:0]     shreg;
  logic           bit_done;
  logic           half_done;
  logic           push_c;
  logic           pop_ok;
  logic           fifo_full_c, fifo_empty_c;

  // Two-flop synchronizer plus one delayed copy for falling-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= rx;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  assign bit_done  = (cnt == CW'(CLKS_PER_BIT - 1));
  assign half_done = (cnt == CW'(HALF_BIT - 1));
  assign push_c    = (state == STOP) && bit_done && rxs;
  assign pop_ok    = rx_pop && !fifo_empty_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rxs_prev && !rxs) state <= START;
        end
        START: begin
          if (half_done) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt       <= '0;
            frame_err <= !rxs;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  overrun <= 1'b0;
    else if (push_c && fifo_full_c && !pop_ok)   overrun <= 1'b1;
    else if (clr_err)                            overrun <= 1'b0;
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_c),
    .din     (shreg),
    .pop     (rx_pop),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c),
    .head    (rx_data),
    .valid   (rx_valid)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at the default parameters.
module tb_uart_rx;

  localparam int unsigned CPB   = 87;
  localparam int          NEVER = 99;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx_pop;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int lat, fe, fe_idle;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_pop    (rx_pop),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting on a negedge; optional reset window by slot.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int rst_on, input int rst_off,
                            output int latency, output int fe_cycles);
    logic [9:0] bits;
    logic       v0;
    int         n;
    bits      = {stop, b, 1'b0};
    v0        = rx_valid;
    n         = 0;
    latency   = 0;
    fe_cycles = 0;
    for (int s = 0; s < 10; s++) begin
      rx = bits[s];
      for (int c = 0; c < int'(CPB); c++) begin
        if (s == rst_on && c == 40)  rst_n = 1'b0;
        if (s == rst_off && c == 40) rst_n = 1'b1;
        @(negedge clk);
        n++;
        if (latency == 0 && !v0 && rx_valid) latency = n;
        if (frame_err) fe_cycles++;
      end
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int cycles, output int fe_cycles);
    fe_cycles = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (frame_err) fe_cycles++;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    rx_pop  = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data",   32'(rx_data),   32'h0);
    check("reset_rx_valid",  32'(rx_valid),  32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun",   32'(overrun),   32'h0);
    rst_n = 1'b1;
    idle(10, fe_idle);

    // Single byte, latency from the start edge.
    @(negedge clk);
    send_frame(8'h55, 1'b1, NEVER, NEVER, lat, fe);
    check("b55_latency_lo", 32'(lat >= 828), 32'h1);
    check("b55_latency_hi", 32'(lat <= 830), 32'h1);
    check("b55_data",       32'(rx_data),    32'h55);
    check("b55_frame_err",  32'(fe),         32'h0);
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    check("b55_popped_valid", 32'(rx_valid), 32'h0);

    // Back-to-back bytes, then two pops.
    send_frame(8'hA3, 1'b1, NEVER, NEVER, lat, fe);
    send_frame(8'h0F, 1'b1, NEVER, NEVER, lat, fe);
    idle(5, fe_idle);
    check("b2b_first_data",  32'(rx_data),  32'hA3);
    check("b2b_first_valid", 32'(rx_valid), 32'h1);
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    check("b2b_second_data", 32'(rx_data),  32'h0F);
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    check("b2b_empty_valid", 32'(rx_valid), 32'h0);
    check("b2b_empty_data",  32'(rx_data),  32'h0);

    // Five bytes into a four-entry FIFO, then back-to-back drain.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, NEVER, NEVER, lat, fe);
    idle(5, fe_idle);
    check("ovr_flag",       32'(overrun),  32'h1);
    check("ovr_head_valid", 32'(rx_valid), 32'h1);
    check("ovr_head_01",    32'(rx_data),  32'h01);
    rx_pop = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("ovr_drain_%0d", i), 32'(rx_data), 32'(i));
    end
    @(negedge clk);
    rx_pop = 1'b0;
    check("ovr_drained_valid", 32'(rx_valid), 32'h0);
    check("ovr_sticky",        32'(overrun),  32'h1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);

    // Stop bit driven low.
    send_frame(8'h7E, 1'b0, NEVER, NEVER, lat, fe);
    idle(200, fe_idle);
    check("ferr_pulse_cycles", 32'(fe + fe_idle), 32'h1);
    check("ferr_no_push",      32'(rx_valid),     32'h0);

    // Short low glitch on an idle line.
    rx = 1'b0;
    idle(20, fe);
    rx = 1'b1;
    idle(1000, fe_idle);
    check("glitch_no_push",  32'(rx_valid),     32'h0);
    check("glitch_no_ferr",  32'(fe + fe_idle), 32'h0);
    check("glitch_no_ovr",   32'(overrun),      32'h0);

    // Reset asserted in bit 4 of 0xC3, released in bit 6, then 0x3C.
    send_frame(8'hC3, 1'b1, 5, 7, lat, fe);
    idle(20, fe_idle);
    check("rst_mid_no_push", 32'(rx_valid), 32'h0);
    send_frame(8'h3C, 1'b1, NEVER, NEVER, lat, fe);
    idle(5, fe_idle);
    check("rst_resync_data",  32'(rx_data),  32'h3C);
    check("rst_resync_valid", 32'(rx_valid), 32'h1);
    check("rst_resync_ferr",  32'(fe + fe_idle), 32'h0);
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
    check("rst_only_one", 32'(rx_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
